// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice path.
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        APPLY = 2'd2
    } alloc_state_e;

    localparam int NOTE_W     = 4;
    localparam int VOICES_DEF = 4;
    localparam int AGE_W_DEF  = 8;

    typedef struct packed {
        logic              on;
        logic [NOTE_W-1:0] note;
    } note_event_t;

endpackage

// File: rtl/voice_slot.sv
// One voice slot: gate, note and saturating age registers.
module voice_slot #(
    parameter int note_width_p = 4,
    parameter int age_width_p  = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    load_i,
    input  logic                    clear_i,
    input  logic                    age_inc_i,
    input  logic [note_width_p-1:0] note_i,
    output logic                    gate_o,
    output logic [note_width_p-1:0] note_o,
    output logic [age_width_p-1:0]  age_o
);

    // Load wins over increment so a (re)triggered voice always restarts at age 0.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            gate_o <= 1'b0;
            note_o <= '0;
            age_o  <= '0;
        end else if (load_i) begin
            gate_o <= 1'b1;
            note_o <= note_i;
            age_o  <= '0;
        end else begin
            if (clear_i)
                gate_o <= 1'b0;
            if (age_inc_i && gate_o && (age_o != '1))
                age_o <= age_o + 1'b1;
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: serial scan of the slots, then one apply cycle
// that retriggers, fills a free slot, or steals the oldest voice.
module voice_alloc
    import synth_pkg::*;
#(
    parameter int voices_p     = VOICES_DEF,
    parameter int note_width_p = NOTE_W,
    parameter int age_width_p  = AGE_W_DEF
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             note_valid_i,
    output logic                             note_ready_o,
    input  logic [note_width_p-1:0]          note_i,
    input  logic                             note_on_i,
    output logic [voices_p-1:0]              voice_gate_o,
    output logic [voices_p*note_width_p-1:0] voice_note_o,
    output logic [voices_p-1:0]              voice_start_o,
    output logic                             steal_o
);

    localparam int IDX_W = $clog2(voices_p);

    alloc_state_e r_state, w_state_next;

    logic [IDX_W-1:0]        r_idx, r_match_idx, r_free_idx, r_old_idx;
    logic                    r_match_found, r_free_found, r_old_found;
    logic [age_width_p-1:0]  r_old_age;
    logic                    r_evt_on;
    logic [note_width_p-1:0] r_evt_note;

    logic [age_width_p-1:0]  w_age [voices_p];
    logic                    w_cur_gate;
    logic [note_width_p-1:0] w_cur_note;
    logic [age_width_p-1:0]  w_cur_age;
    logic                    w_accept, w_apply, w_steal;
    logic [IDX_W-1:0]        w_target;
    logic [voices_p-1:0]     w_load, w_clear, w_age_inc;

    assign w_accept   = note_valid_i && note_ready_o;
    assign w_cur_gate = voice_gate_o[r_idx];
    assign w_cur_note = voice_note_o[r_idx*note_width_p +: note_width_p];
    assign w_cur_age  = w_age[r_idx];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = SCAN;
            SCAN:    if (r_idx == IDX_W'(voices_p - 1)) w_state_next = APPLY;
            APPLY:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Priority: match retriggers, else lowest free slot, else steal the oldest.
    always_comb begin
        note_ready_o = (r_state == IDLE) && !reset_i;
        w_apply      = (r_state == APPLY);
        w_target     = r_old_idx;
        w_steal      = 1'b0;
        w_load       = '0;
        w_clear      = '0;
        w_age_inc    = '0;
        if (r_match_found)
            w_target = r_match_idx;
        else if (r_free_found)
            w_target = r_free_idx;
        else
            w_steal = w_apply && r_evt_on;
        for (int v = 0; v < voices_p; v++) begin
            if (w_apply && r_evt_on) begin
                w_load[v]    = (w_target == IDX_W'(v));
                w_age_inc[v] = 1'b1;
            end else if (w_apply) begin
                w_clear[v] = r_match_found && (r_match_idx == IDX_W'(v));
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_idx         <= '0;
            r_match_idx   <= '0;
            r_free_idx    <= '0;
            r_old_idx     <= '0;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_old_found   <= 1'b0;
            r_old_age     <= '0;
            r_evt_on      <= 1'b0;
            r_evt_note    <= '0;
            voice_start_o <= '0;
            steal_o       <= 1'b0;
        end else begin
            voice_start_o <= w_load;
            steal_o       <= w_steal;
            if (r_state == IDLE && w_accept) begin
                r_evt_on      <= note_on_i;
                r_evt_note    <= note_i;
                r_idx         <= '0;
                r_match_found <= 1'b0;
                r_free_found  <= 1'b0;
                r_old_found   <= 1'b0;
            end else if (r_state == SCAN) begin
                r_idx <= r_idx + 1'b1;
                if (w_cur_gate && (w_cur_note == r_evt_note) && !r_match_found) begin
                    r_match_found <= 1'b1;
                    r_match_idx   <= r_idx;
                end
                if (!w_cur_gate && !r_free_found) begin
                    r_free_found <= 1'b1;
                    r_free_idx   <= r_idx;
                end
                // Strict compare keeps the lowest index on equal ages.
                if (w_cur_gate && (!r_old_found || (w_cur_age > r_old_age))) begin
                    r_old_found <= 1'b1;
                    r_old_idx   <= r_idx;
                    r_old_age   <= w_cur_age;
                end
            end
        end
    end

    for (genvar gi = 0; gi < voices_p; gi++) begin : g_slot
        voice_slot #(
            .note_width_p (note_width_p),
            .age_width_p  (age_width_p)
        ) u_slot (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .load_i    (w_load[gi]),
            .clear_i   (w_clear[gi]),
            .age_inc_i (w_age_inc[gi]),
            .note_i    (r_evt_note),
            .gate_o    (voice_gate_o[gi]),
            .note_o    (voice_note_o[gi*note_width_p +: note_width_p]),
            .age_o     (w_age[gi])
        );
    end

endmodule

// File: doc/voice_alloc.md
# voice_alloc

Polyphonic voice allocator between the keypad decoder and the oscillator bank. It accepts note-on/note-off events over a valid/ready handshake and assigns each note to one of `voices_p` voice slots. When all slots are busy it steals the oldest voice. Per-voice note, gate and start-pulse outputs drive the per-voice phase_inc lookup, phase accumulators and wave selection downstream.

## Interface
- `voices_p`, 4: number of voice slots (2..16).
- `note_width_p`, 4: note index width, matching the note LUT index.
- `age_width_p`, 8: per-voice saturating age counter width.

- `clk_i` input, 1: system clock (48 kHz domain).
- `reset_i` input, 1: asynchronous, active-high reset.
- `note_valid_i` input, 1: event present.
- `note_ready_o` output, 1: allocator can accept an event.
- `note_i` input, `note_width_p`: note index of the event.
- `note_on_i` input, 1: 1 = key press, 0 = key release.
- `voice_gate_o` output, `voices_p`: voice active (sounding).
- `voice_note_o` output, `voices_p*note_width_p`: flattened per-voice note, voice v at bits [v*nw +: nw].
- `voice_start_o` output, `voices_p`: one-cycle pulse when a voice is (re)triggered; downstream resets the phase on it.
- `steal_o` output, 1: one-cycle pulse when a note-on steals an active voice.

## Operation
- FSM states: IDLE, SCAN, APPLY.
  - `note_ready_o` = (state == IDLE) and not `reset_i`.
  - IDLE: on `note_valid_i && note_ready_o`, latch `note_i`/`note_on_i`, clear scan index and result flags, go to SCAN.
  - SCAN: inspect slot `idx` each cycle, then `idx++`. Record:
    - first matching slot (gate=1 and note equal to the latched note);
    - lowest-index free slot (gate=0);
    - oldest active slot (largest age; ties go to the lowest index).
  - SCAN moves to APPLY after `idx == voices_p-1`.
  - APPLY: single cycle, then back to IDLE.
- Note-on resolution, in priority order:
  - Matching slot: retrigger it.
  - Else free slot: use it.
  - Else: steal the oldest slot and pulse `steal_o`.
  - Target slot: gate=1, note=latched, age=0, `voice_start_o[target]` pulses. Every other active slot increments its age, saturating at 2^`age_width_p`-1.
- Note-off:
  - Matching slot: gate cleared; note field retained; ages unchanged; no pulses.
  - No match: no state change.
- Ages of inactive slots are don't-care and are never compared.
- Events arriving while `note_ready_o`=0 are held by the producer; the allocator never drops a handshaked event.

## Timing
- Reset values: `voice_gate_o`=0, `voice_note_o`=0, all ages=0, `voice_start_o`=0, `steal_o`=0, state=IDLE. `note_ready_o` is 0 while `reset_i` is high and 1 in the first cycle after deassertion.
- Acceptance at edge k:
  - SCAN occupies edges k+1..k+`voices_p`.
  - APPLY updates registers at edge k+`voices_p`+1.
  - Outputs and pulses are visible in that cycle. `note_ready_o` returns to 1 in the same cycle.
- Maximum throughput: one event every `voices_p`+2 cycles (6 at default).
- All outputs are registered. Pulses last exactly one cycle. At most one bit of `voice_start_o` is set per event.
- Reset asserted mid-SCAN/APPLY: the event in flight is discarded and everything returns to reset values asynchronously.
- Simultaneous retrigger and steal cannot occur: a match suppresses stealing.

## Structure
- Shared `synth_pkg`:
  - `alloc_state_e` (IDLE/SCAN/APPLY);
  - `NOTE_W` = 4 and the default voice count constant;
  - `note_event_t` struct {on, note}.
- One sub-module, `voice_slot`: per-slot gate/note/age registers, with load, clear and saturating age-increment controls. It is instantiated `voices_p` times with a generate loop. Scan and priority logic stay in `voice_alloc`.

## Test plan
- Reset release, then on(5) → after 6 cycles: gate=0001, slot0 note=5, start=0001 for 1 cycle, steal=0; `note_ready_o` low for exactly 5 cycles after acceptance.
- on(1), on(2), on(3), on(4) → gate=1111, notes 1,2,3,4; then on(9) → slot0 stolen, note=9, start=0001, steal pulses once.
- Notes 1,2,3 held, then on(2) again → slot1 retriggered, start=0010, no new slot used, steal=0; then off(2) → gate=0101.
- off(7) with no voice holding 7 → no output change, no pulses, ready returns after 6 cycles.
- 300 consecutive on(3) events with on(4) held in slot1 → slot1 age saturates at 255 without wrapping; on(5) then on(6) with 4 slots full → slot1 stolen.
- `reset_i` asserted 2 cycles into SCAN → all outputs 0 immediately, the in-flight event has no effect after release, and the next event allocates slot0.
